alu_reservation_station: RTL and testbench

//  Issue buffer between decode/rename and the integer ALU. Accepts one decoded op per cycle
//  (ALUControl, MemSize, two source operands as value-or-tag, dest tag), captures operands from the

---
 rtl/alu_reservation_station.sv | 164 ++++++++++++++++
 tb/tb_alu_reservation_station.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// Reservation station feeding the integer ALU.
// It accepts one decoded op per cycle. Sources that are not ready capture their values from the
// common data bus (CDB). It issues one operand-ready op per cycle using a valid/ready handshake.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   flush              squash every entry (branch mispredict)
//   dispatch_*         allocation side: op code, byte/word size, two value-or-tag sources, dest tag
//   cdb_*              result broadcast used for operand wakeup
//   issue_*            op presented to the ALU, freed on issue_valid && issue_ready
//   occupancy          number of valid entries
//
// Optional feature: define ALU_RS_OLDEST_FIRST_EN to select the oldest eligible entry through a
// DEPTH x DEPTH age matrix. By default the lowest-index eligible entry issues.
module alu_reservation_station #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [3:0]               ALUControl,
  input  logic                     MemSize,
  input  logic                     src1_rdy,
  input  logic                     src2_rdy,
  input  logic [TAG_W-1:0]         src1_tag,
  input  logic [TAG_W-1:0]         src2_tag,
  input  logic [DATA_W-1:0]        src1_val,
  input  logic [DATA_W-1:0]        src2_val,
  input  logic [TAG_W-1:0]         dest_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [3:0]               issue_ALUControl,
  output logic                     issue_MemSize,
  output logic [DATA_W-1:0]        issue_op1,
  output logic [DATA_W-1:0]        issue_op2,
  output logic [TAG_W-1:0]         issue_dest_tag,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, s1_rdy_q, s2_rdy_q, msz_q, eligible;
  logic [3:0]        op_q   [DEPTH];
  logic [TAG_W-1:0]  s1_tag_q [DEPTH];
  logic [TAG_W-1:0]  s2_tag_q [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [DATA_W-1:0] s1_val_q [DEPTH];
  logic [DATA_W-1:0] s2_val_q [DEPTH];

  logic [IDX_W-1:0]  free_idx, issue_idx;
  logic              do_alloc, do_issue;

  // Lowest-index free slot. This is only meaningful when the station is not full.
  always_comb begin
    free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occupancy = occupancy + (IDX_W + 1)'(valid_q[i]);
    end
  end

  // Eligibility comes from registered readiness only. An entry woken at an edge issues from the
  // following cycle.
  assign eligible = valid_q & s1_rdy_q & s2_rdy_q;

`ifdef ALU_RS_OLDEST_FIRST_EN
  // age_q[j][i] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] blocked;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (eligible[j] && age_q[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  always_comb begin
    issue_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (eligible[i] && !blocked[i]) issue_idx = IDX_W'(i);
    end
  end

  // The newcomer is younger than everyone. Stale bits of invalid entries are masked by eligibility
  // and rewritten on allocation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= '0;
    end else if (do_alloc) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        age_q[free_idx][j] <= 1'b0;
        if (IDX_W'(j) != free_idx) age_q[j][free_idx] <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    issue_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (eligible[i]) issue_idx = IDX_W'(i);
    end
  end
`endif

  assign dispatch_ready   = ~&valid_q;
  assign issue_valid      = |eligible;
  assign issue_ALUControl = op_q[issue_idx];
  assign issue_MemSize    = msz_q[issue_idx];
  assign issue_op1        = s1_val_q[issue_idx];
  assign issue_op2        = s2_val_q[issue_idx];
  assign issue_dest_tag   = dest_q[issue_idx];

  assign do_alloc = dispatch_valid & dispatch_ready & ~flush & ~reset;
  assign do_issue = issue_valid & issue_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid_q[i] && !s1_rdy_q[i] && cdb_valid && s1_tag_q[i] == cdb_tag) begin
          s1_rdy_q[i] <= 1'b1;
          s1_val_q[i] <= cdb_data;
        end
        if (valid_q[i] && !s2_rdy_q[i] && cdb_valid && s2_tag_q[i] == cdb_tag) begin
          s2_rdy_q[i] <= 1'b1;
          s2_val_q[i] <= cdb_data;
        end
      end
      if (do_issue) valid_q[issue_idx] <= 1'b0;
      // The issued entry is valid and the free slot is not, so these writes never collide.
      if (do_alloc) begin
        valid_q[free_idx]  <= 1'b1;
        op_q[free_idx]     <= ALUControl;
        msz_q[free_idx]    <= MemSize;
        dest_q[free_idx]   <= dest_tag;
        s1_tag_q[free_idx] <= src1_tag;
        s2_tag_q[free_idx] <= src2_tag;
        // Bypass: a source produced by this cycle's broadcast is captured on entry.
        s1_rdy_q[free_idx] <= src1_rdy | (cdb_valid && src1_tag == cdb_tag);
        s2_rdy_q[free_idx] <= src2_rdy | (cdb_valid && src2_tag == cdb_tag);
        s1_val_q[free_idx] <= src1_rdy ? src1_val : cdb_data;
        s2_val_q[free_idx] <= src2_rdy ? src2_val : cdb_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        reset, flush, dispatch_valid, dispatch_ready;
  logic [3:0]  ALUControl;
  logic        MemSize, src1_rdy, src2_rdy;
  logic [5:0]  src1_tag, src2_tag, dest_tag, cdb_tag, issue_dest_tag;
  logic [31:0] src1_val, src2_val, cdb_data, issue_op1, issue_op2;
  logic        cdb_valid, issue_valid, issue_ready, issue_MemSize;
  logic [3:0]  issue_ALUControl;
  logic [2:0]  occupancy;

  alu_reservation_station dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .ALUControl(ALUControl), .MemSize(MemSize),
    .src1_rdy(src1_rdy), .src2_rdy(src2_rdy), .src1_tag(src1_tag), .src2_tag(src2_tag),
    .src1_val(src1_val), .src2_val(src2_val), .dest_tag(dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_ALUControl(issue_ALUControl), .issue_MemSize(issue_MemSize),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_dest_tag(issue_dest_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic        msz;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  dest;
  } iss_t;

  iss_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: every accepted issue is compared with the head of the expected queue.
  always @(negedge clk) begin
    iss_t got, exp;
    if (!reset && issue_valid && issue_ready) begin
      got = '{op: issue_ALUControl, msz: issue_MemSize, op1: issue_op1, op2: issue_op2,
              dest: issue_dest_tag};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got %h, required no issue", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL issue_payload: got %h, required %h", got, exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic disp(input logic [3:0] op, input logic msz,
                      input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] v2,
                      input logic [5:0] d);
    dispatch_valid = 1'b1;
    ALUControl = op; MemSize = msz; dest_tag = d;
    src1_rdy = r1; src1_tag = t1; src1_val = v1;
    src2_rdy = r2; src2_tag = t2; src2_val = v2;
    step();
    dispatch_valid = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = v;
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; issue_ready = 1'b1;
    ALUControl = '0; MemSize = 1'b0; src1_rdy = 1'b0; src2_rdy = 1'b0;
    src1_tag = '0; src2_tag = '0; src1_val = '0; src2_val = '0; dest_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;

    // 1 reset
    step(); step();
    reset = 1'b0;
    check("reset_dispatch_ready", 32'(dispatch_ready), 1);
    check("reset_issue_valid", 32'(issue_valid), 0);
    check("reset_occupancy", 32'(occupancy), 0);

    // 2 ready ADD
    sb.push_back('{op: 4'b0010, msz: 1'b0, op1: 5, op2: 7, dest: 3});
    disp(4'b0010, 1'b0, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd3);
    check("add_issue_valid", 32'(issue_valid), 1);
    step();
    check("add_occupancy", 32'(occupancy), 0);

    // 3 wakeup from CDB
    sb.push_back('{op: 4'b0100, msz: 1'b0, op1: 32'hA5, op2: 3, dest: 5});
    disp(4'b0100, 1'b0, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd3, 6'd5);
    step();
    check("wake_hold_issue_valid", 32'(issue_valid), 0);
    cdb(6'd9, 32'hA5);
    check("wake_issue_valid", 32'(issue_valid), 1);
    step();

    // 4 dispatch bypass, LUI code carried like any op, byte size
    sb.push_back('{op: 4'b1111, msz: 1'b1, op1: 32'h22, op2: 32'h11, dest: 7});
    cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h11;
    disp(4'b1111, 1'b1, 1'b1, 6'd0, 32'h22, 1'b0, 6'd4, 32'd0, 6'd7);
    cdb_valid = 1'b0;
    check("bypass_issue_valid", 32'(issue_valid), 1);
    step();
    check("bypass_occupancy", 32'(occupancy), 0);

    // 5 fill then flush; a flushed cycle accepts nothing and wakes nothing
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(4'b0000, 1'b0, 1'b0, 6'(30 + i), 32'd0, 1'b1, 6'd0, 32'd0, 6'd20);
    end
    check("full_dispatch_ready", 32'(dispatch_ready), 0);
    check("full_occupancy", 32'(occupancy), 4);
    disp(4'b0000, 1'b0, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 6'd21);
    check("full_reject_occupancy", 32'(occupancy), 4);
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 6'd30;
    disp(4'b0000, 1'b0, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 6'd22);
    flush = 1'b0; cdb_valid = 1'b0;
    check("flush_occupancy", 32'(occupancy), 0);
    check("flush_dispatch_ready", 32'(dispatch_ready), 1);
    check("flush_issue_valid", 32'(issue_valid), 0);
    issue_ready = 1'b1;
    step();

    // 6 issue order: A slot0 ready, B/C/D unready on tag 20, A issues, E fills slot0
    issue_ready = 1'b0;
    sb.push_back('{op: 4'b0001, msz: 1'b0, op1: 1, op2: 2, dest: 11});
`ifdef ALU_RS_OLDEST_FIRST_EN
    sb.push_back('{op: 4'b0010, msz: 1'b0, op1: 32'hCD, op2: 32'h200, dest: 12});
    sb.push_back('{op: 4'b0011, msz: 1'b0, op1: 32'h300, op2: 32'hCD, dest: 13});
    sb.push_back('{op: 4'b0101, msz: 1'b1, op1: 32'hCD, op2: 32'hCD, dest: 14});
    sb.push_back('{op: 4'b0110, msz: 1'b0, op1: 32'hE1, op2: 32'hE2, dest: 15});
`else
    sb.push_back('{op: 4'b0110, msz: 1'b0, op1: 32'hE1, op2: 32'hE2, dest: 15});
    sb.push_back('{op: 4'b0010, msz: 1'b0, op1: 32'hCD, op2: 32'h200, dest: 12});
    sb.push_back('{op: 4'b0011, msz: 1'b0, op1: 32'h300, op2: 32'hCD, dest: 13});
    sb.push_back('{op: 4'b0101, msz: 1'b1, op1: 32'hCD, op2: 32'hCD, dest: 14});
`endif
    disp(4'b0001, 1'b0, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 6'd11);
    disp(4'b0010, 1'b0, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'h200, 6'd12);
    disp(4'b0011, 1'b0, 1'b1, 6'd0, 32'h300, 1'b0, 6'd20, 32'd0, 6'd13);
    disp(4'b0101, 1'b1, 1'b0, 6'd20, 32'd0, 1'b0, 6'd20, 32'd0, 6'd14);
    check("order_full_occupancy", 32'(occupancy), 4);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("order_after_a_occupancy", 32'(occupancy), 3);
    disp(4'b0110, 1'b0, 1'b1, 6'd0, 32'hE1, 1'b1, 6'd0, 32'hE2, 6'd15);
    cdb(6'd20, 32'hCD);
    check("order_woken_occupancy", 32'(occupancy), 4);
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("order_drained_occupancy", 32'(occupancy), 0);

    // 7 dispatch and issue in one cycle leave occupancy unchanged
    issue_ready = 1'b0;
    sb.push_back('{op: 4'b0111, msz: 1'b0, op1: 32'h71, op2: 32'h72, dest: 31});
    sb.push_back('{op: 4'b1000, msz: 1'b0, op1: 32'h55, op2: 32'h82, dest: 32});
    disp(4'b0111, 1'b0, 1'b1, 6'd0, 32'h71, 1'b1, 6'd0, 32'h72, 6'd31);
    issue_ready = 1'b1;
    disp(4'b1000, 1'b0, 1'b0, 6'd40, 32'd0, 1'b1, 6'd0, 32'h82, 6'd32);
    check("dual_occupancy", 32'(occupancy), 1);
    check("dual_issue_valid", 32'(issue_valid), 0);
    cdb(6'd40, 32'h55);

    // Drain with a cycle budget
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check("scoreboard_leftover", 32'(sb.size()), 0);
    step();
    check("final_occupancy", 32'(occupancy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
